// File: rtl/nmr_cpmg_sequencer.sv
// rtl/nmr_cpmg_sequencer.sv - multi-scan CPMG pulse sequencer with T1 prep, echo skip and acquisition windows
// Optional NMR_SEQ_XY4_EN: P180 phase alternates y/x by echo index instead of constant y.
module nmr_cpmg_sequencer #(
  parameter int DATABUS_WIDTH = 32,
  parameter int PHASE_W       = 2
) (
  input  logic                     PULSEPROG_CLK,
  input  logic                     RESET_N,
  input  logic                     START,
  input  logic                     ABORT,
  input  logic [DATABUS_WIDTH-1:0] T1_PULSE180,
  input  logic [DATABUS_WIDTH-1:0] T1_DELAY,
  input  logic [DATABUS_WIDTH-1:0] PULSE90,
  input  logic [DATABUS_WIDTH-1:0] DELAY_NO_ACQ,
  input  logic [DATABUS_WIDTH-1:0] PULSE180,
  input  logic [DATABUS_WIDTH-1:0] DELAY_WITH_ACQ,
  input  logic [DATABUS_WIDTH-1:0] ECHO_PER_SCAN,
  input  logic [DATABUS_WIDTH-1:0] ECHO_SKIP,
  input  logic [DATABUS_WIDTH-1:0] RX_DELAY,
  input  logic [DATABUS_WIDTH-1:0] SAMPLES_PER_ECHO,
  input  logic [DATABUS_WIDTH-1:0] SCAN_COUNT,
  input  logic [DATABUS_WIDTH-1:0] SCAN_DELAY,
  input  logic                     PHASE_CYCLE,
  output logic                     FSMSTAT,
  output logic                     DONE,
  output logic                     TX_PULSE_EN,
  output logic [PHASE_W-1:0]       TX_PHASE,
  output logic                     EN_RX,
  output logic                     ACQ_WND,
  output logic [DATABUS_WIDTH-1:0] ECHO_IDX,
  output logic [DATABUS_WIDTH-1:0] SCAN_IDX
);

  localparam int DBW = DATABUS_WIDTH;
  localparam logic [DBW-1:0] L_ONE = {{(DBW-1){1'b0}}, 1'b1};
  localparam logic [PHASE_W-1:0] L_PH_X  = '0;
  localparam logic [PHASE_W-1:0] L_PH_Y  = PHASE_W'(1);
  localparam logic [PHASE_W-1:0] L_PH_MX = PHASE_W'(2);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T1P  = 4'd1;
  localparam logic [3:0] S_T1D  = 4'd2;
  localparam logic [3:0] S_P90  = 4'd3;
  localparam logic [3:0] S_DNA  = 4'd4;
  localparam logic [3:0] S_P180 = 4'd5;
  localparam logic [3:0] S_DACQ = 4'd6;
  localparam logic [3:0] S_SDLY = 4'd7;
  // Pseudo-state for "scan finished"; resolved before registering, never stored.
  localparam logic [3:0] S_END  = 4'd8;

  logic [3:0]         r_state;
  logic [DBW-1:0]     r_cnt;
  logic [DBW-1:0]     r_echo_idx;
  logic [DBW-1:0]     r_scan_idx;
  logic               r_fsmstat;
  logic               r_done;
  logic               r_tx;
  logic [PHASE_W-1:0] r_phase;
  logic               r_rx;
  logic               r_acq;

  logic [DBW-1:0]     w_dur;
  logic               w_last_tick;
  logic               w_echo_zero;
  logic               w_more_echo;
  logic               w_last_scan;
  logic [3:0]         w_post_echo;
  logic [3:0]         w_echo_first;
  logic [3:0]         w_echo_end;
  logic [3:0]         w_after_dna;
  logic [3:0]         w_after_p90;
  logic [3:0]         w_after_t1d;
  logic [3:0]         w_after_t1p;
  logic [3:0]         w_scan_entry;

  logic [3:0]         w_tgt;
  logic               w_take;
  logic               w_inc_echo;
  logic [3:0]         w_nxt_state;
  logic [DBW-1:0]     w_nxt_cnt;
  logic [DBW-1:0]     w_nxt_echo;
  logic [DBW-1:0]     w_nxt_scan;
  logic               w_nxt_done;
  logic               w_nxt_rx;
  logic               w_nxt_acq;
  logic [PHASE_W-1:0] w_nxt_phase;
  logic [PHASE_W-1:0] w_p180_phase;

  always_comb begin
    w_dur = '0;
    case (r_state)
      S_T1P:   w_dur = T1_PULSE180;
      S_T1D:   w_dur = T1_DELAY;
      S_P90:   w_dur = PULSE90;
      S_DNA:   w_dur = DELAY_NO_ACQ;
      S_P180:  w_dur = PULSE180;
      S_DACQ:  w_dur = DELAY_WITH_ACQ;
      S_SDLY:  w_dur = SCAN_DELAY;
      default: w_dur = '0;
    endcase
  end

  assign w_last_tick = (r_cnt == (w_dur - L_ONE));
  assign w_more_echo = ((r_echo_idx + L_ONE) < ECHO_PER_SCAN);
  assign w_last_scan = (SCAN_COUNT <= L_ONE) || (r_scan_idx >= (SCAN_COUNT - L_ONE));

  // Successor chain: each entry names the first state with nonzero duration.
  assign w_echo_zero  = (PULSE180 == '0) && (DELAY_WITH_ACQ == '0);
  assign w_post_echo  = (SCAN_DELAY != '0) ? S_SDLY : S_END;
  assign w_echo_first = (PULSE180 != '0) ? S_P180 : S_DACQ;
  assign w_echo_end   = w_more_echo ? w_echo_first : w_post_echo;
  assign w_after_dna  = ((ECHO_PER_SCAN != '0) && !w_echo_zero) ? w_echo_first : w_post_echo;
  assign w_after_p90  = (DELAY_NO_ACQ != '0) ? S_DNA : w_after_dna;
  assign w_after_t1d  = (PULSE90 != '0) ? S_P90 : w_after_p90;
  assign w_after_t1p  = (T1_DELAY != '0) ? S_T1D : w_after_t1d;
  assign w_scan_entry = (T1_PULSE180 != '0) ? S_T1P : w_after_t1d;

  always_comb begin
    w_tgt       = r_state;
    w_take      = 1'b0;
    w_inc_echo  = 1'b0;
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_echo  = r_echo_idx;
    w_nxt_scan  = r_scan_idx;
    w_nxt_done  = 1'b0;
    if (ABORT) begin
      w_nxt_state = S_IDLE;
      w_nxt_cnt   = '0;
    end else if (r_state == S_IDLE) begin
      if (START) begin
        w_tgt      = w_scan_entry;
        w_take     = 1'b1;
        w_nxt_echo = '0;
        w_nxt_scan = '0;
      end
    end else if (w_last_tick) begin
      w_take = 1'b1;
      case (r_state)
        S_T1P:   w_tgt = w_after_t1p;
        S_T1D:   w_tgt = w_after_t1d;
        S_P90:   w_tgt = w_after_p90;
        S_DNA:   w_tgt = w_after_dna;
        S_P180: begin
          w_tgt      = (DELAY_WITH_ACQ != '0) ? S_DACQ : w_echo_end;
          w_inc_echo = (DELAY_WITH_ACQ == '0) && w_more_echo;
        end
        S_DACQ: begin
          w_tgt      = w_echo_end;
          w_inc_echo = w_more_echo;
        end
        S_SDLY:  w_tgt = S_END;
        default: w_tgt = S_IDLE;
      endcase
    end else begin
      w_nxt_cnt = r_cnt + L_ONE;
    end

    if (w_take) begin
      w_nxt_cnt = '0;
      if (w_inc_echo) w_nxt_echo = r_echo_idx + L_ONE;
      if (w_tgt == S_END) begin
        // A scan of zero total length cannot be repeated meaningfully; finish instead.
        if (w_last_scan || (r_state == S_IDLE) || (w_scan_entry == S_END)) begin
          w_nxt_state = S_IDLE;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_state = w_scan_entry;
          w_nxt_scan  = r_scan_idx + L_ONE;
          w_nxt_echo  = '0;
        end
      end else begin
        w_nxt_state = w_tgt;
      end
    end
  end

`ifdef NMR_SEQ_XY4_EN
  assign w_p180_phase = w_nxt_echo[0] ? L_PH_X : L_PH_Y;
`else
  assign w_p180_phase = L_PH_Y;
`endif

  assign w_nxt_rx  = (w_nxt_state == S_DACQ) && (w_nxt_echo >= ECHO_SKIP);
  assign w_nxt_acq = w_nxt_rx && (w_nxt_cnt >= RX_DELAY) &&
                     ((w_nxt_cnt - RX_DELAY) < SAMPLES_PER_ECHO);

  always_comb begin
    w_nxt_phase = r_phase;
    case (w_nxt_state)
      S_T1P:   w_nxt_phase = L_PH_X;
      S_P90:   w_nxt_phase = (PHASE_CYCLE && w_nxt_scan[0]) ? L_PH_MX : L_PH_X;
      S_P180:  w_nxt_phase = w_p180_phase;
      default: w_nxt_phase = r_phase;
    endcase
  end

  always_ff @(posedge PULSEPROG_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_echo_idx <= '0;
      r_scan_idx <= '0;
      r_fsmstat  <= 1'b0;
      r_done     <= 1'b0;
      r_tx       <= 1'b0;
      r_phase    <= '0;
      r_rx       <= 1'b0;
      r_acq      <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_echo_idx <= w_nxt_echo;
      r_scan_idx <= w_nxt_scan;
      r_fsmstat  <= (w_nxt_state != S_IDLE);
      r_done     <= w_nxt_done;
      r_tx       <= (w_nxt_state == S_T1P) || (w_nxt_state == S_P90) || (w_nxt_state == S_P180);
      r_phase    <= w_nxt_phase;
      r_rx       <= w_nxt_rx;
      r_acq      <= w_nxt_acq;
    end
  end

  assign FSMSTAT     = r_fsmstat;
  assign DONE        = r_done;
  assign TX_PULSE_EN = r_tx;
  assign TX_PHASE    = r_phase;
  assign EN_RX       = r_rx;
  assign ACQ_WND     = r_acq;
  assign ECHO_IDX    = r_echo_idx;
  assign SCAN_IDX    = r_scan_idx;

endmodule

// File: tb/tb_nmr_cpmg_sequencer.sv
// tb/tb_nmr_cpmg_sequencer.sv - table-driven bench for nmr_cpmg_sequencer plus reset/phase/abort sequences
module tb_nmr_cpmg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        pc = 1'b0;
  logic [31:0] t1p = '0, t1d = '0, p90 = '0, dna = '0, p180 = '0, dwa = '0;
  logic [31:0] epc = '0, eskip = '0, rxd = '0, spe = '0, scnt = '0, sdly = '0;
  logic        fsmstat, done, tx, en_rx, acq;
  logic [1:0]  phase;
  logic [31:0] echo_idx, scan_idx;

  always #5 clk = ~clk;

  nmr_cpmg_sequencer #(.DATABUS_WIDTH(32), .PHASE_W(2)) dut (
    .PULSEPROG_CLK(clk), .RESET_N(rst_n), .START(start), .ABORT(abort),
    .T1_PULSE180(t1p), .T1_DELAY(t1d), .PULSE90(p90), .DELAY_NO_ACQ(dna),
    .PULSE180(p180), .DELAY_WITH_ACQ(dwa), .ECHO_PER_SCAN(epc), .ECHO_SKIP(eskip),
    .RX_DELAY(rxd), .SAMPLES_PER_ECHO(spe), .SCAN_COUNT(scnt), .SCAN_DELAY(sdly),
    .PHASE_CYCLE(pc), .FSMSTAT(fsmstat), .DONE(done), .TX_PULSE_EN(tx), .TX_PHASE(phase),
    .EN_RX(en_rx), .ACQ_WND(acq), .ECHO_IDX(echo_idx), .SCAN_IDX(scan_idx)
  );

  typedef struct {
    int t1p; int t1d; int p90; int dna; int p180; int dwa;
    int epc; int skip; int rxd; int spe; int scnt; int sdly;
    int busy; int tx; int txp; int rx; int acq; int acqw; int off; int done;
  } vec_t;

  vec_t vecs[11];
  int checks = 0;
  int failures = 0;
  int m_busy, m_tx, m_txp, m_rx, m_acq, m_acqw, m_off, m_done, m_cyc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    t1p = v.t1p; t1d = v.t1d; p90 = v.p90; dna = v.dna; p180 = v.p180; dwa = v.dwa;
    epc = v.epc; eskip = v.skip; rxd = v.rxd; spe = v.spe; scnt = v.scnt; sdly = v.sdly;
  endtask

  task automatic run_seq(input int restart_at);
    logic ptx, prx, pacq;
    int   rxc;
    bit   off_seen;
    m_busy = 0; m_tx = 0; m_txp = 0; m_rx = 0; m_acq = 0; m_acqw = 0; m_off = 0; m_done = 0;
    ptx = 0; prx = 0; pacq = 0; rxc = 0; off_seen = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_cyc = 0;
    while (fsmstat && m_cyc < 2000) begin
      m_busy++;
      if (tx) m_tx++;
      if (tx && !ptx) m_txp++;
      if (en_rx) m_rx++;
      if (en_rx) rxc = prx ? rxc + 1 : 0;
      if (acq) m_acq++;
      if (acq && !pacq) begin
        m_acqw++;
        if (!off_seen) begin m_off = rxc; off_seen = 1; end
      end
      if (done) m_done++;
      ptx = tx; prx = en_rx; pacq = acq;
      start = (m_cyc == restart_at);
      @(posedge clk); #1;
      m_cyc++;
    end
    start = 1'b0;
    chk("run_timeout", int'(m_cyc >= 2000), 0);
    for (int k = 0; k < 3; k++) begin
      if (done) m_done++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vec_t b;
    int   ph_exp[8];
    int   ph_got[8];
    int   np, cyc, dcnt, bcnt;
    logic ptx;

    b = '{0, 0, 4, 6, 8, 20, 3, 1, 5, 10, 1, 7, 101, 28, 4, 40, 20, 2, 5, 1};
    vecs[0] = b;
    vecs[1] = b; vecs[1].rxd = 15; vecs[1].acq = 10; vecs[1].off = 15;
    vecs[2] = b; vecs[2].epc = 0; vecs[2].busy = 17; vecs[2].tx = 4; vecs[2].txp = 1;
    vecs[2].rx = 0; vecs[2].acq = 0; vecs[2].acqw = 0; vecs[2].off = 0;
    vecs[3] = b; vecs[3].p90 = 0; vecs[3].busy = 97; vecs[3].tx = 24; vecs[3].txp = 3;
    vecs[4] = '{5, 3, 4, 6, 8, 20, 2, 0, 0, 30, 2, 4, 156, 50, 8, 80, 80, 4, 0, 1};
    vecs[5] = b; vecs[5].skip = 3; vecs[5].rx = 0; vecs[5].acq = 0; vecs[5].acqw = 0; vecs[5].off = 0;
    vecs[6] = b; vecs[6].spe = 0; vecs[6].acq = 0; vecs[6].acqw = 0; vecs[6].off = 0;
    vecs[7] = b; vecs[7].scnt = 0;
    vecs[8] = b; vecs[8].rxd = 20; vecs[8].acq = 0; vecs[8].acqw = 0; vecs[8].off = 0;
    vecs[9] = b; vecs[9].t1d = 50;
    vecs[10] = '{0, 0, 2, 3, 2, 4, 1, 0, 1, 2, 3, 0, 33, 12, 6, 12, 6, 3, 1, 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_fsmstat", int'(fsmstat), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tx", int'(tx), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_en_rx", int'(en_rx), 0);
    chk("rst_acq", int'(acq), 0);
    chk("rst_echo", int'(echo_idx), 0);
    chk("rst_scan", int'(scan_idx), 0);

    for (int i = 0; i < 11; i++) begin
      set_cfg(vecs[i]);
      pc = 1'b0;
      run_seq(-1);
      chk($sformatf("v%0d_busy", i), m_busy, vecs[i].busy);
      chk($sformatf("v%0d_tx", i), m_tx, vecs[i].tx);
      chk($sformatf("v%0d_txp", i), m_txp, vecs[i].txp);
      chk($sformatf("v%0d_rx", i), m_rx, vecs[i].rx);
      chk($sformatf("v%0d_acq", i), m_acq, vecs[i].acq);
      chk($sformatf("v%0d_acqw", i), m_acqw, vecs[i].acqw);
      chk($sformatf("v%0d_off", i), m_off, vecs[i].off);
      chk($sformatf("v%0d_done", i), m_done, vecs[i].done);
      repeat (2) @(posedge clk);
      #1;
    end

    // START while busy is ignored
    set_cfg(vecs[0]);
    run_seq(10);
    chk("restart_busy", m_busy, 101);
    chk("restart_done", m_done, 1);
    chk("restart_txp", m_txp, 4);

    // Phase cycling over two scans
    set_cfg(vecs[0]); scnt = 2; pc = 1'b1;
`ifdef NMR_SEQ_XY4_EN
    ph_exp = '{0, 1, 0, 1, 2, 1, 0, 1};
`else
    ph_exp = '{0, 1, 1, 1, 2, 1, 1, 1};
`endif
    np = 0; ptx = 0; cyc = 0; dcnt = 0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    while (fsmstat && cyc < 2000) begin
      if (tx && !ptx) begin
        if (np < 8) ph_got[np] = int'(phase);
        if (np == 4) chk("pc_scan1_idx", int'(scan_idx), 1);
        np++;
      end
      ptx = tx;
      @(posedge clk); #1; cyc++;
    end
    if (done) dcnt++;
    chk("pc_pulses", np, 8);
    chk("pc_done", dcnt, 1);
    for (int k = 0; k < 8; k++)
      if (k < np) chk($sformatf("pc_phase%0d", k), ph_got[k], ph_exp[k]);
    pc = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset mid-P180
    set_cfg(vecs[0]);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (!(tx && echo_idx == 1) && cyc < 500) begin @(posedge clk); #1; cyc++; end
    chk("mid_p180_reached", int'(cyc < 500), 1);
    #1; rst_n = 1'b0; #1;
    chk("arst_fsmstat", int'(fsmstat), 0);
    chk("arst_tx", int'(tx), 0);
    chk("arst_phase", int'(phase), 0);
    chk("arst_echo", int'(echo_idx), 0);
    chk("arst_en_rx", int'(en_rx), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_idle", int'(fsmstat), 0);

    // ABORT with ACQ_WND high
    set_cfg(vecs[0]);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (!acq && cyc < 500) begin @(posedge clk); #1; cyc++; end
    chk("abort_acq_reached", int'(acq), 1);
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    chk("abort_fsmstat", int'(fsmstat), 0);
    chk("abort_tx", int'(tx), 0);
    chk("abort_en_rx", int'(en_rx), 0);
    chk("abort_acq", int'(acq), 0);
    chk("abort_done_now", int'(done), 0);
    dcnt = 0; bcnt = 0;
    for (int k = 0; k < 120; k++) begin
      if (done) dcnt++;
      if (fsmstat) bcnt++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_stays_idle", bcnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
